// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and mux encodings for the MIPS controllers
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_ERROR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps (aluop, funct) to the 3-bit ALU control code
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALU_ADD;
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_OR:  alucontrol_o = ALU_OR;
                    FUNCT_SLT: alucontrol_o = ALU_SLT;
                    // unknown R-type functions execute as ADD rather than trapping
                    default:   alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM; ILLEGAL_TRAP_EN traps unknown opcodes
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT    = 0,
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       memwrite_o,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       pcen_o,
    output logic       regwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic       instr_done_o,
    output logic       error_o
);

    localparam int     CW          = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam state_t RESET_STATE = RESET_TO_FETCH ? S_FETCH : S_HALT;

    state_t          state_q, state_d;
    logic [CW-1:0]   tmo_q, tmo_d;

    logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
    logic       regwrite, regdst, memtoreg, alusrca, alu_en, instr_done;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [2:0] alu_dec;

    alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct_i      (funct_i),
        .alucontrol_o (alu_dec)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RESET_STATE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        alu_en     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_HALT: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                alu_en  = 1'b1;
                if (mem_ready_i) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut while the opcode is decoded
                alusrcb = SRCB_IMM_SH;
                alu_en  = 1'b1;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_ERROR;
`else
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_en  = 1'b1;
                state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready_i) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                alu_en  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                alu_en     = 1'b1;
                branch     = 1'b1;
                pcsrc      = PCSRC_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                alu_en  = 1'b1;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcwrite    = 1'b1;
                pcsrc      = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // counts consecutive unanswered request cycles; a ready cycle clears it
        if (MEM_TIMEOUT > 0 && mem_req && !mem_ready_i) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == CW'(MEM_TIMEOUT)) state_d = S_ERROR;
        end
    end

    // outputs are forced low while reset is held so an in-flight access is dropped at once
    assign mem_req_o    = reset_ni & mem_req;
    assign memwrite_o   = reset_ni & memwrite;
    assign iord_o       = reset_ni & iord;
    assign irwrite_o    = reset_ni & irwrite;
    assign pcen_o       = reset_ni & (pcwrite | (branch & zero_i));
    assign regwrite_o   = reset_ni & regwrite;
    assign regdst_o     = reset_ni & regdst;
    assign memtoreg_o   = reset_ni & memtoreg;
    assign alusrca_o    = reset_ni & alusrca;
    assign alusrcb_o    = {2{reset_ni}} & alusrcb;
    assign pcsrc_o      = {2{reset_ni}} & pcsrc;
    assign alucontrol_o = {3{reset_ni & alu_en}} & alu_dec;
    assign instr_done_o = reset_ni & instr_done;
    assign error_o      = reset_ni & (state_q == S_ERROR);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for the multi-cycle MIPS control FSM
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       error;
    } ctl_t;

    typedef enum int {
        E_HALT, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR,
        E_EXEC, E_ALUWB, E_BRANCH, E_ADDIEX, E_ADDIWB, E_JUMP, E_ERROR
    } st_e;

    typedef struct {
        logic       ready;
        logic       start;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        ctl_t       exp;
    } ent_t;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, error;

    logic       h_start, h_mem_ready;
    logic       h_mem_req, h_memwrite, h_iord, h_irwrite, h_pcen, h_regwrite, h_regdst, h_memtoreg, h_alusrca;
    logic [1:0] h_alusrcb, h_pcsrc;
    logic [2:0] h_alucontrol;
    logic       h_instr_done, h_error;

    ctl_t obs, obs_h;
    assign obs   = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
                    alusrcb, pcsrc, alucontrol, instr_done, error};
    assign obs_h = {h_mem_req, h_memwrite, h_iord, h_irwrite, h_pcen, h_regwrite, h_regdst, h_memtoreg, h_alusrca,
                    h_alusrcb, h_pcsrc, h_alucontrol, h_instr_done, h_error};

    int total = 0;
    int bad   = 0;
    ent_t  q[$];
    string tq[$];
    logic       p_start;
    logic [5:0] p_op, p_fn;
    logic       p_z;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_TIMEOUT(4), .RESET_TO_FETCH(1'b1)) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .op_i(op), .funct_i(funct),
        .zero_i(zero), .mem_ready_i(mem_ready),
        .mem_req_o(mem_req), .memwrite_o(memwrite), .iord_o(iord), .irwrite_o(irwrite),
        .pcen_o(pcen), .regwrite_o(regwrite), .regdst_o(regdst), .memtoreg_o(memtoreg),
        .alusrca_o(alusrca), .alusrcb_o(alusrcb), .pcsrc_o(pcsrc), .alucontrol_o(alucontrol),
        .instr_done_o(instr_done), .error_o(error)
    );

    mips_multicycle_control #(.MEM_TIMEOUT(0), .RESET_TO_FETCH(1'b0)) dut_h (
        .clk_i(clk), .reset_ni(rst_n), .start_i(h_start), .op_i(6'b000010), .funct_i(6'b000000),
        .zero_i(1'b0), .mem_ready_i(h_mem_ready),
        .mem_req_o(h_mem_req), .memwrite_o(h_memwrite), .iord_o(h_iord), .irwrite_o(h_irwrite),
        .pcen_o(h_pcen), .regwrite_o(h_regwrite), .regdst_o(h_regdst), .memtoreg_o(h_memtoreg),
        .alusrca_o(h_alusrca), .alusrcb_o(h_alusrcb), .pcsrc_o(h_pcsrc), .alucontrol_o(h_alucontrol),
        .instr_done_o(h_instr_done), .error_o(h_error)
    );

    function automatic logic [2:0] exp_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctl_t model(input st_e st, input logic flag, input logic [5:0] fn);
        ctl_t e;
        e = '0;
        case (st)
            E_FETCH:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.alucontrol = 3'b010; e.irwrite = flag; e.pcen = flag; end
            E_DECODE: begin e.alusrcb = 2'b11; e.alucontrol = 3'b010; e.instr_done = flag; end
            E_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
            E_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            E_MEMWB:  begin e.regwrite = 1; e.memtoreg = 1; e.instr_done = 1; end
            E_MEMWR:  begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; e.instr_done = flag; end
            E_EXEC:   begin e.alusrca = 1; e.alucontrol = exp_alu(fn); end
            E_ALUWB:  begin e.regwrite = 1; e.regdst = 1; e.instr_done = 1; end
            E_BRANCH: begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = flag; e.instr_done = 1; end
            E_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
            E_ADDIWB: begin e.regwrite = 1; e.instr_done = 1; end
            E_JUMP:   begin e.pcen = 1; e.pcsrc = 2'b10; e.instr_done = 1; end
            E_ERROR:  begin e.error = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t o, input ctl_t x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, x);
        end
    endtask

    task automatic push(input string tag, input st_e st, input logic rdy, input logic flag);
        ent_t e;
        e.ready = rdy;
        e.start = p_start;
        e.op    = p_op;
        e.funct = p_fn;
        e.zero  = p_z;
        e.exp   = model(st, flag, p_fn);
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic push_instr(input string tag, input logic [5:0] o, input logic [5:0] fn,
                              input logic z, input int fw, input int mw);
        logic legal;
        p_op = o;
        p_fn = fn;
        p_z  = z;
        legal = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
                (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
        for (int i = 0; i < fw; i++) push(tag, E_FETCH, 1'b0, 1'b0);
        push(tag, E_FETCH, 1'b1, 1'b1);
        push(tag, E_DECODE, 1'b1, !legal && !TRAP);
        case (o)
            6'b100011: begin
                push(tag, E_MEMADR, 1'b1, 1'b0);
                for (int i = 0; i < mw; i++) push(tag, E_MEMRD, 1'b0, 1'b0);
                push(tag, E_MEMRD, 1'b1, 1'b0);
                push(tag, E_MEMWB, 1'b1, 1'b0);
            end
            6'b101011: begin
                push(tag, E_MEMADR, 1'b1, 1'b0);
                for (int i = 0; i < mw; i++) push(tag, E_MEMWR, 1'b0, 1'b0);
                push(tag, E_MEMWR, 1'b1, 1'b1);
            end
            6'b000000: begin
                push(tag, E_EXEC, 1'b1, 1'b0);
                push(tag, E_ALUWB, 1'b1, 1'b0);
            end
            6'b000100: push(tag, E_BRANCH, 1'b1, z);
            6'b001000: begin
                push(tag, E_ADDIEX, 1'b1, 1'b0);
                push(tag, E_ADDIWB, 1'b1, 1'b0);
            end
            6'b000010: push(tag, E_JUMP, 1'b1, 1'b0);
            default: if (TRAP) for (int i = 0; i < 3; i++) push(tag, E_ERROR, 1'b1, 1'b0);
        endcase
    endtask

    task automatic drain();
        ent_t  e;
        string t;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = tq.pop_front();
            mem_ready = e.ready;
            start     = e.start;
            op        = e.op;
            funct     = e.funct;
            zero      = e.zero;
            @(negedge clk);
            check(t, obs, e.exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check(tag, obs, '0);
        check({tag, "_h"}, obs_h, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = '0; funct = '0;
        h_start = 1'b0; h_mem_ready = 1'b0;
        p_start = 1'b0; p_op = '0; p_fn = '0; p_z = 1'b0;

        @(negedge clk);
        check("reset", obs, '0);
        check("reset_h", obs_h, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        push_instr("lw",       6'b100011, 6'b000000, 1'b0, 0, 0);
        push_instr("r_add",    6'b000000, 6'b100000, 1'b0, 0, 0);
        push_instr("r_sub",    6'b000000, 6'b100010, 1'b0, 0, 0);
        push_instr("r_and",    6'b000000, 6'b100100, 1'b0, 0, 0);
        push_instr("r_or",     6'b000000, 6'b100101, 1'b0, 0, 0);
        push_instr("r_slt",    6'b000000, 6'b101010, 1'b0, 0, 0);
        push_instr("r_unk",    6'b000000, 6'b111111, 1'b0, 0, 0);
        push_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, 0, 0);
        push_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, 0, 0);
        push_instr("sw_wait3", 6'b101011, 6'b000000, 1'b0, 0, 3);
        p_start = 1'b1;
        push_instr("addi",     6'b001000, 6'b000000, 1'b0, 0, 0);
        p_start = 1'b0;
        push_instr("j",        6'b000010, 6'b000000, 1'b0, 0, 0);
        push_instr("lw_waits", 6'b100011, 6'b000000, 1'b0, 3, 3);
        push_instr("illegal",  6'b111111, 6'b000000, 1'b0, 0, 0);
        if (!TRAP) push_instr("after_nop", 6'b000010, 6'b000000, 1'b0, 0, 0);
        drain();
        do_reset("reset_pulse");

        p_op = 6'b101011; p_fn = '0; p_z = 1'b0;
        push("mid_sw", E_FETCH, 1'b1, 1'b1);
        push("mid_sw", E_DECODE, 1'b1, 1'b0);
        push("mid_sw", E_MEMADR, 1'b1, 1'b0);
        push("mid_sw", E_MEMWR, 1'b0, 1'b0);
        push("mid_sw", E_MEMWR, 1'b0, 1'b0);
        drain();
        do_reset("reset_mid_access");

        p_op = 6'b100011;
        for (int i = 0; i < 4; i++) push("tmo_wait", E_FETCH, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push("tmo_error", E_ERROR, 1'b1, 1'b0);
        drain();
        do_reset("tmo_reset");
        push_instr("lw_after_tmo", 6'b100011, 6'b000000, 1'b0, 0, 0);
        drain();

        @(negedge clk);
        check("halt_idle", obs_h, '0);
        @(posedge clk);
        #1 h_start = 1'b1;
        @(negedge clk);
        check("halt_start_cycle", obs_h, '0);
        @(posedge clk);
        #1 h_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("halt_fetch_no_tmo", obs_h, model(E_FETCH, 1'b0, 6'b000000));
            @(posedge clk);
            #1;
        end
        h_mem_ready = 1'b1;
        @(negedge clk);
        check("halt_fetch_ready", obs_h, model(E_FETCH, 1'b1, 6'b000000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
